// File: rtl/bp_pkg.sv
// Shared branch-predictor types and constants.
// Checkpoint layout and PHT index hashing.
package bp_pkg;

    localparam int BP_GHR_WIDTH = 4;
    localparam int BP_PHT_DEPTH = 7;
    localparam int BP_HPC_WIDTH = BP_PHT_DEPTH - BP_GHR_WIDTH;

    typedef struct packed {
        logic [BP_HPC_WIDTH-1:0] hashed_pc;
        logic [BP_GHR_WIDTH-1:0] ghr;
        logic                    pred;
    } bp_ckpt_t;

    function automatic logic [BP_PHT_DEPTH-1:0] bp_pht_index(
        input logic [BP_HPC_WIDTH-1:0] hashed_pc,
        input logic [BP_GHR_WIDTH-1:0] ghr
    );
        return {hashed_pc, ghr};
    endfunction

endpackage

// File: rtl/bp_checkpoint_queue_if.sv
// Decode/Memory-side bundle of the branch checkpoint queue.
// master drives allocate/resolve, slave is the queue.
interface bp_checkpoint_queue_if
    import bp_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PHT_DEPTH = BP_PHT_DEPTH,
    parameter int GHR_WIDTH = BP_GHR_WIDTH
);
    localparam int HW = PHT_DEPTH - GHR_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [HW-1:0]        alloc_hashed_pc;
    logic [GHR_WIDTH-1:0] alloc_ghr;
    logic                 alloc_pred;
    logic                 resolve_valid;
    logic                 resolve_taken;
    logic                 squash;
    logic                 upd_valid;
    logic [PHT_DEPTH-1:0] upd_index;
    logic                 upd_taken;
    logic                 mispredict;
    logic [GHR_WIDTH-1:0] restore_ghr;
    logic [CW-1:0]        count;
    logic                 empty;

    modport master (
        output alloc_valid, alloc_hashed_pc, alloc_ghr, alloc_pred,
        output resolve_valid, resolve_taken, squash,
        input  alloc_ready, upd_valid, upd_index, upd_taken,
        input  mispredict, restore_ghr, count, empty
    );

    modport slave (
        input  alloc_valid, alloc_hashed_pc, alloc_ghr, alloc_pred,
        input  resolve_valid, resolve_taken, squash,
        output alloc_ready, upd_valid, upd_index, upd_taken,
        output mispredict, restore_ghr, count, empty
    );

endinterface

// File: rtl/bp_ckpt_fifo.sv
// Circular checkpoint storage with push, pop and flush-all.
// Pointers carry one extra bit so full and empty differ.
module bp_ckpt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;

    // Next pointers: flush collapses tail onto the post-pop head.
    always_comb begin
        head_d = head_q + PW'(pop_i);
        tail_d = tail_q + PW'(push_i);
        if (flush_i) begin
            tail_d = head_d;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o  = mem_q[head_q[AW-1:0]];
    assign count_o = tail_q - head_q;

endmodule

// File: rtl/bp_checkpoint_queue.sv
// In-order queue of in-flight branch predictions.
// Resolves oldest entry into a PHT update and GHR repair.
module bp_checkpoint_queue
    import bp_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PHT_DEPTH = BP_PHT_DEPTH,
    parameter int GHR_WIDTH = BP_GHR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    bp_checkpoint_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    bp_ckpt_t      alloc_ent;
    bp_ckpt_t      head_ent;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          res_acc;
    logic          mis;
    logic          push;
    logic          flush;

    logic                 upd_valid_q, upd_valid_d;
    logic [PHT_DEPTH-1:0] upd_index_q, upd_index_d;
    logic                 upd_taken_q, upd_taken_d;
    logic                 mispredict_q, mispredict_d;
    logic [GHR_WIDTH-1:0] restore_ghr_q, restore_ghr_d;

    assign alloc_ent.hashed_pc = bus.alloc_hashed_pc;
    assign alloc_ent.ghr       = bus.alloc_ghr;
    assign alloc_ent.pred      = bus.alloc_pred;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Squash beats resolve; a mispredict kills the same-cycle alloc.
    always_comb begin
        res_acc = bus.resolve_valid && !empty && !bus.squash;
        mis     = res_acc && (bus.resolve_taken != head_ent.pred);
        push    = bus.alloc_valid && !full && !bus.squash && !mis;
        flush   = bus.squash || mis;
    end

    bp_ckpt_fifo #(
        .W     ($bits(bp_ckpt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (alloc_ent),
        .pop_i   (res_acc),
        .flush_i (flush),
        .dout_o  (head_ent),
        .count_o (count)
    );

    // Update/restore payload: pulses by default, data held until next resolve.
    always_comb begin
        upd_valid_d   = res_acc;
        mispredict_d  = mis;
        upd_index_d   = upd_index_q;
        upd_taken_d   = upd_taken_q;
        restore_ghr_d = restore_ghr_q;
        if (res_acc) begin
            upd_index_d   = bp_pht_index(head_ent.hashed_pc, head_ent.ghr);
            upd_taken_d   = bus.resolve_taken;
            restore_ghr_d = {head_ent.ghr[GHR_WIDTH-2:0], bus.resolve_taken};
        end
    end

    // Registered predictor-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid_q   <= 1'b0;
            upd_index_q   <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            restore_ghr_q <= '0;
        end else begin
            upd_valid_q   <= upd_valid_d;
            upd_index_q   <= upd_index_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            restore_ghr_q <= restore_ghr_d;
        end
    end

    assign bus.alloc_ready = !full;
    assign bus.count       = count;
    assign bus.empty       = empty;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_index   = upd_index_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.restore_ghr = restore_ghr_q;

endmodule

// File: tb/tb_bp_checkpoint_queue.sv
// Bench for the branch checkpoint queue: queue model plus
// directed scenarios with literal expectations.
module tb_bp_checkpoint_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [2:0] h;
        logic [3:0] g;
        logic       p;
    } ent_t;

    logic clk;
    logic rst;

    bp_checkpoint_queue_if #(.DEPTH(DEPTH)) bus ();

    bp_checkpoint_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    ent_t       mq[$];
    logic       e_uv  = 1'b0;
    logic       e_mis = 1'b0;
    logic [6:0] e_idx = '0;
    logic       e_tk  = 1'b0;
    logic [3:0] e_rg  = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Reference model: queue semantics straight from the rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            e_uv  <= 1'b0;
            e_mis <= 1'b0;
            e_idx <= '0;
            e_tk  <= 1'b0;
            e_rg  <= '0;
        end else begin
            automatic bit   do_alloc;
            automatic bit   was_full = (mq.size() == DEPTH);
            automatic ent_t e;
            automatic ent_t n;
            e_uv  <= 1'b0;
            e_mis <= 1'b0;
            if (bus.squash) begin
                mq.delete();
            end else begin
                do_alloc = bus.alloc_valid && !was_full;
                if (bus.resolve_valid && mq.size() != 0) begin
                    e = mq.pop_front();
                    e_uv  <= 1'b1;
                    e_idx <= {e.h, e.g};
                    e_tk  <= bus.resolve_taken;
                    e_rg  <= {e.g[2:0], bus.resolve_taken};
                    if (bus.resolve_taken != e.p) begin
                        e_mis <= 1'b1;
                        mq.delete();
                        do_alloc = 0;
                    end
                end
                if (do_alloc) begin
                    n.h = bus.alloc_hashed_pc;
                    n.g = bus.alloc_ghr;
                    n.p = bus.alloc_pred;
                    mq.push_back(n);
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(bus.count), 32'(mq.size()));
            chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
            chk("alloc_ready", 32'(bus.alloc_ready),
                32'(mq.size() != DEPTH));
            chk("upd_valid", 32'(bus.upd_valid), 32'(e_uv));
            chk("mispredict", 32'(bus.mispredict), 32'(e_mis));
            chk("upd_index", 32'(bus.upd_index), 32'(e_idx));
            chk("upd_taken", 32'(bus.upd_taken), 32'(e_tk));
            chk("restore_ghr", 32'(bus.restore_ghr), 32'(e_rg));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid     = 1'b0;
        bus.alloc_hashed_pc = '0;
        bus.alloc_ghr       = '0;
        bus.alloc_pred      = 1'b0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_taken   = 1'b0;
        bus.squash          = 1'b0;
    endtask

    task automatic set_alloc(input logic [2:0] h, input logic [3:0] g,
                             input logic p);
        bus.alloc_valid     = 1'b1;
        bus.alloc_hashed_pc = h;
        bus.alloc_ghr       = g;
        bus.alloc_pred      = p;
    endtask

    task automatic alloc(input logic [2:0] h, input logic [3:0] g,
                         input logic p);
        set_alloc(h, g, p);
        step();
        idle();
    endtask

    task automatic resolve(input logic t);
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = t;
        step();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_ready", 32'(bus.alloc_ready), 32'd1);
        chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
        #10 rst = 1'b0;
        step();

        // Asynchronous reset in the middle of activity.
        alloc(3'b001, 4'b0001, 1'b1);
        alloc(3'b010, 4'b0010, 1'b1);
        alloc(3'b011, 4'b0011, 1'b1);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        #3 rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_ready", 32'(bus.alloc_ready), 32'd1);
        chk("arst_upd_valid", 32'(bus.upd_valid), 32'd0);
        #2 rst = 1'b0;
        step();

        // Correct prediction.
        alloc(3'b101, 4'b0110, 1'b1);
        resolve(1'b1);
        chk("cp_upd_valid", 32'(bus.upd_valid), 32'd1);
        chk("cp_upd_index", 32'(bus.upd_index), 32'b1010110);
        chk("cp_upd_taken", 32'(bus.upd_taken), 32'd1);
        chk("cp_mispredict", 32'(bus.mispredict), 32'd0);
        chk("cp_count", 32'(bus.count), 32'd0);
        step();

        // Mispredict flush of younger entries.
        alloc(3'b010, 4'b1001, 1'b0);
        alloc(3'b100, 4'b0101, 1'b1);
        alloc(3'b111, 4'b1110, 1'b0);
        resolve(1'b1);
        chk("mp_mispredict", 32'(bus.mispredict), 32'd1);
        chk("mp_restore", 32'(bus.restore_ghr), 32'b0011);
        chk("mp_upd_index", 32'(bus.upd_index), 32'b0101001);
        chk("mp_count", 32'(bus.count), 32'd0);
        resolve(1'b0);
        chk("mp_late_upd_valid", 32'(bus.upd_valid), 32'd0);
        step();

        // Full boundary and pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            automatic logic [3:0] iv = 4'(i);
            alloc(iv[2:0], ~iv, 1'b1);
        end
        chk("full_ready", 32'(bus.alloc_ready), 32'd0);
        chk("full_count", 32'(bus.count), 32'd8);
        set_alloc(3'b110, 4'b1010, 1'b1);
        resolve(1'b1);
        chk("full_drop_count", 32'(bus.count), 32'd7);
        chk("full_drop_index", 32'(bus.upd_index), 32'b0001111);
        alloc(3'b110, 4'b1010, 1'b1);
        chk("refill_count", 32'(bus.count), 32'd8);
        for (int i = 1; i <= DEPTH; i++) begin
            automatic logic [3:0] iv = 4'(i);
            automatic logic [6:0] ex = (i == DEPTH) ? 7'b1101010
                                                    : {iv[2:0], ~iv};
            resolve(1'b1);
            chk("wrap_order", 32'(bus.upd_index), 32'(ex));
        end
        chk("wrap_empty", 32'(bus.empty), 32'd1);
        step();

        // Resolve on empty does not see same-cycle alloc.
        set_alloc(3'b011, 4'b0101, 1'b0);
        resolve(1'b1);
        chk("er_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("er_count", 32'(bus.count), 32'd1);
        resolve(1'b0);
        chk("er2_upd_valid", 32'(bus.upd_valid), 32'd1);
        chk("er2_mispredict", 32'(bus.mispredict), 32'd0);
        chk("er2_index", 32'(bus.upd_index), 32'b0110101);
        step();

        // Squash overrides resolve.
        alloc(3'b001, 4'b1100, 1'b1);
        alloc(3'b010, 4'b1101, 1'b0);
        alloc(3'b011, 4'b1110, 1'b1);
        alloc(3'b100, 4'b1111, 1'b0);
        chk("sq_pre_count", 32'(bus.count), 32'd4);
        bus.squash = 1'b1;
        set_alloc(3'b101, 4'b0000, 1'b1);
        resolve(1'b1);
        chk("sq_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("sq_count", 32'(bus.count), 32'd0);
        chk("sq_empty", 32'(bus.empty), 32'd1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
